// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// One digit is lit per slot of REFRESH_DIV clocks. Hex nibbles are decoded to
// active-low segments. Display data is double-buffered (pending -> active) and
// handed over only at the frame boundary, so a frame is never shown half-updated.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   en_i,
   input  logic                    load_i,
   input  logic                    blank_i,
   input  logic                    lz_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   // One complete display image: nibbles, decimal points and enables.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] data;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   en;
   } disp_buf_t;

   logic [CNT_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   disp_buf_t             pend_q, pend_d;
   disp_buf_t             act_q, act_d;
   disp_buf_t             in_buf;
   logic                  pend_vld_q, pend_vld_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_q, frame_d;
   logic                  tick, wrap;

   logic [3:0]            nib;
   logic                  dig_dp, dig_en, suppress, zero_run, visible;

   assign in_buf = {data_i, dp_i, en_i};

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Prescaler, scan index and frame-boundary detection.
   always_comb begin
      // NOTE: every signal of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      tick    = (presc_q == CNT_MAX);
      wrap    = tick && (idx_q == IDX_MAX);
      presc_d = tick ? '0 : presc_q + CNT_W'(1);
      idx_d   = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      end
      frame_d = wrap;
   end

   // Buffer handoff: loads go to pending, pending moves to active at the
   // boundary; a load on the boundary itself bypasses straight to active.
   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      act_d      = act_q;
      if (wrap) begin
         if (load_i) begin
            act_d = in_buf;
         end else if (pend_vld_q) begin
            act_d = pend_q;
         end
         pend_vld_d = 1'b0;
      end else if (load_i) begin
         pend_d     = in_buf;
         pend_vld_d = 1'b1;
      end
   end

   // Decode the current slot; leading-zero run is tracked from the top digit down.
   always_comb begin
      nib      = '0;
      dig_dp   = 1'b0;
      dig_en   = 1'b0;
      suppress = 1'b0;
      zero_run = lz_i;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (act_q.data[4*k +: 4] == 4'h0);
         if (int'(idx_q) == k) begin
            nib      = act_q.data[4*k +: 4];
            dig_dp   = act_q.dp[k];
            dig_en   = act_q.en[k];
            suppress = zero_run && (k != 0);
         end
      end
      visible = !blank_i && dig_en && !suppress;
      an_d    = '1;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      if (visible) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_q);
         seg_d = hex_to_seg(nib);
         dp_d  = ~dig_dp;
      end
   end

   // State and output registers; reset clears both buffers and darkens the display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         idx_q      <= '0;
         pend_q     <= '0;
         act_q      <= '0;
         pend_vld_q <= 1'b0;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         an_q       <= '1;
         frame_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         act_q      <= act_d;
         pend_vld_q <= pend_vld_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         frame_q    <= frame_d;
      end
   end

   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver
// Scoreboard bench: expected slot contents are queued when a display image is
// driven and popped as each scan slot is sampled on the falling clock edge.
module tb_seven_seg_scan_driver;

   localparam int ND = 8;
   localparam int RD = 4;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [31:0]   data_i;
   logic [7:0]    dp_i, en_i;
   logic          load_i, blank_i, lz_i;
   logic [6:0]    seg_o;
   logic          dp_o, frame_o;
   logic [7:0]    an_o;

   logic [3:0]    data1_i;
   logic          dp1_i, en1_i, load1_i;
   logic [6:0]    seg1_o;
   logic          dp1_o, an1_o, frame1_o;

   int            chk_cnt = 0;
   int            err_cnt = 0;
   slot_t         exp_q[$];

   seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .dp_i(dp_i), .en_i(en_i),
      .load_i(load_i), .blank_i(blank_i), .lz_i(lz_i), .seg_o(seg_o),
      .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
   );

   seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_i(data1_i), .dp_i(dp1_i), .en_i(en1_i),
      .load_i(load1_i), .blank_i(1'b0), .lz_i(1'b0), .seg_o(seg1_o),
      .dp_o(dp1_o), .an_o(an1_o), .frame_o(frame1_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[h];
   endfunction

   function automatic slot_t model(input logic [31:0] d, input logic [7:0] dp,
                                   input logic [7:0] en, input logic blank,
                                   input logic lz, input int k);
      slot_t s;
      logic  sup;
      sup = 1'b0;
      if (lz && k > 0) begin
         sup = 1'b1;
         for (int j = k; j < ND; j++) if (d[4*j +: 4] != 4'h0) sup = 1'b0;
      end
      s.an  = 8'hFF;
      s.seg = 7'h7F;
      s.dp  = 1'b1;
      if (!blank && en[k] && !sup) begin
         s.an  = ~(8'h01 << k);
         s.seg = hex2seg(d[4*k +: 4]);
         s.dp  = ~dp[k];
      end
      return s;
   endfunction

   task automatic push_frame(input logic [31:0] d, input logic [7:0] dp,
                             input logic [7:0] en, input logic blank, input logic lz);
      for (int k = 0; k < ND; k++) exp_q.push_back(model(d, dp, en, blank, lz, k));
   endtask

   // Called on a falling edge; the strobe lasts exactly one clock.
   task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
      data_i = d;
      dp_i   = dp;
      en_i   = en;
      load_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (frame_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_frame"}, frame_o, 1'b1);
   endtask

   task automatic sample_one(input string tag);
      slot_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_an"}, an_o, e.an);
         check({tag, "_seg"}, seg_o, e.seg);
         check({tag, "_dp"}, dp_o, e.dp);
      end
   endtask

   // Called on the falling edge where frame_o is high; samples mid-slot.
   task automatic sample_frame(input string tag);
      for (int k = 0; k < ND; k++) begin
         repeat ((k == 0) ? 2 : RD) @(negedge clk);
         sample_one($sformatf("%s_d%0d", tag, k));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n   = 1'b1;
      data_i  = '0;
      dp_i    = '0;
      en_i    = '0;
      load_i  = 1'b0;
      blank_i = 1'b0;
      lz_i    = 1'b0;
      data1_i = '0;
      dp1_i   = 1'b0;
      en1_i   = 1'b0;
      load1_i = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      check("rst_an", an_o, 8'hFF);
      check("rst_seg", seg_o, 7'h7F);
      check("rst_dp", dp_o, 1'b1);
      check("rst_frame", frame_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-digit, undivided instance: index fixed at 0, frame every cycle.
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_frame_%0d", i), frame1_o, 1'b1);
         @(negedge clk);
      end
      data1_i = 4'hA;
      en1_i   = 1'b1;
      dp1_i   = 1'b1;
      load1_i = 1'b1;
      @(negedge clk);
      load1_i = 1'b0;
      @(negedge clk);
      check("t6_seg", seg1_o, 7'h08);
      check("t6_an", an1_o, 1'b0);
      check("t6_dp", dp1_o, 1'b0);
      @(negedge clk);
      check("t6_an_hold", an1_o, 1'b0);
      check("t6_frame_hold", frame1_o, 1'b1);

      // Basic scan of a full image.
      do_load(32'h89ABCDEF, 8'h00, 8'hFF);
      push_frame(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0, 1'b0);
      wait_frame("t1");
      sample_frame("t1");
      wait_frame("t1_per");
      @(negedge clk);
      check("t1_frame_width", frame_o, 1'b0);
      n = 1;
      while (frame_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t1_period", n, ND * RD);

      // Mid-frame load is held until the next boundary.
      repeat (9) @(negedge clk);
      do_load(32'h00000001, 8'h00, 8'hFF);
      exp_q.push_back(model(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0, 1'b0, 4));
      repeat (8) @(negedge clk);
      sample_one("t2_old_d4");
      push_frame(32'h00000001, 8'h00, 8'hFF, 1'b0, 1'b0);
      wait_frame("t2");
      sample_frame("t2");

      // Load on the boundary cycle bypasses into the new frame.
      wait_frame("t3a_sync");
      repeat (ND * RD - 1) @(negedge clk);
      do_load(32'h12345678, 8'h00, 8'hFF);
      check("t3a_bnd_frame", frame_o, 1'b1);
      push_frame(32'h12345678, 8'h00, 8'hFF, 1'b0, 1'b0);
      sample_frame("t3a");

      // Two loads in one frame: the last one wins.
      repeat (4) @(negedge clk);
      do_load(32'hFFFF0000, 8'h00, 8'hFF);
      repeat (5) @(negedge clk);
      do_load(32'h0F1E2D3C, 8'h00, 8'hFF);
      push_frame(32'h0F1E2D3C, 8'h00, 8'hFF, 1'b0, 1'b0);
      wait_frame("t3b");
      sample_frame("t3b");

      // Leading-zero suppression.
      lz_i = 1'b1;
      do_load(32'h00000305, 8'h00, 8'hFF);
      push_frame(32'h00000305, 8'h00, 8'hFF, 1'b0, 1'b1);
      wait_frame("t4a");
      sample_frame("t4a");
      do_load(32'h00000000, 8'h00, 8'hFF);
      push_frame(32'h00000000, 8'h00, 8'hFF, 1'b0, 1'b1);
      wait_frame("t4b");
      sample_frame("t4b");
      lz_i = 1'b0;

      // Decimal points, disabled digit, then global blank.
      do_load(32'h76543210, 8'h05, 8'hFB);
      push_frame(32'h76543210, 8'h05, 8'hFB, 1'b0, 1'b0);
      wait_frame("t5a");
      sample_frame("t5a");
      blank_i = 1'b1;
      push_frame(32'h76543210, 8'h05, 8'hFB, 1'b1, 1'b0);
      wait_frame("t5b");
      sample_frame("t5b");
      wait_frame("t5b_still");
      blank_i = 1'b0;

      // Asynchronous reset mid-scan discards a pending load.
      repeat (5) @(negedge clk);
      do_load(32'hDEADBEEF, 8'hFF, 8'hFF);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_an", an_o, 8'hFF);
      check("t6_async_seg", seg_o, 7'h7F);
      check("t6_async_dp", dp_o, 1'b1);
      check("t6_async_frame", frame_o, 1'b0);
      check("t6_async_seg1", seg1_o, 7'h7F);
      check("t6_async_an1", an1_o, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      push_frame(32'h00000000, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_frame("t6_post");
      sample_frame("t6_post");

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
